// File: rtl/antirebote_multicanal_pkg.sv
// Shared constants and width helpers for the multichannel button debouncer.
package antirebote_multicanal_pkg;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_COUNT_PRESS   = 50000;
  localparam int DEF_COUNT_RELEASE = 501;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_TICK_DIV      = 50000;
  localparam int DEF_LONG_TICKS    = 1000;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return bits_for((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/antirebote_multicanal_canal.sv
// One button channel: synchroniser, asymmetric debounce counter, edge pulses
// and a tick-based long-press detector.
module antirebote_multicanal_canal
  import antirebote_multicanal_pkg::*;
#(
  parameter int COUNT_PRESS   = DEF_COUNT_PRESS,
  parameter int COUNT_RELEASE = DEF_COUNT_RELEASE,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LONG_TICKS    = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic boton,
  output logic nivel,
  output logic pulso_sube,
  output logic pulso_baja,
  output logic pulso_largo
);

  localparam int CW = cnt_width(COUNT_PRESS, COUNT_RELEASE);
  localparam int HW = bits_for(LONG_TICKS + 1);
  localparam logic [CW-1:0] PRESS_LAST   = CW'(COUNT_PRESS - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(COUNT_RELEASE - 1);
  localparam logic [HW-1:0] HOLD_MAX     = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(LONG_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          th_last;
  logic                   accept;
  logic [HW-1:0]          hc;

  assign s       = sync_q[SYNC_STAGES-1];
  assign th_last = s ? PRESS_LAST : RELEASE_LAST;
  assign accept  = (s != nivel) && (cnt == th_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], boton};
    end
  end

  // Any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      nivel      <= 1'b0;
      pulso_sube <= 1'b0;
      pulso_baja <= 1'b0;
    end else begin
      pulso_sube <= accept && s;
      pulso_baja <= accept && !s;
      if (s == nivel) begin
        cnt <= '0;
      end else if (accept) begin
        nivel <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Hold counter saturates at LONG_TICKS so the long pulse fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      pulso_largo <= 1'b0;
    end else begin
      pulso_largo <= nivel && tick && (hc == HOLD_LAST);
      if (!nivel) begin
        hc <= '0;
      end else if (tick && (hc < HOLD_MAX)) begin
        hc <= hc + HW'(1);
      end
    end
  end

endmodule

// File: rtl/antirebote_multicanal.sv
// Multichannel debouncer top: shared long-press tick divider plus one
// independent channel instance per button.
module antirebote_multicanal
  import antirebote_multicanal_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int COUNT_PRESS   = DEF_COUNT_PRESS,
  parameter int COUNT_RELEASE = DEF_COUNT_RELEASE,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int LONG_TICKS    = DEF_LONG_TICKS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] boton_in,
  output logic [N_CH-1:0] boton_out,
  output logic [N_CH-1:0] pulso_press,
  output logic [N_CH-1:0] pulso_release,
  output logic [N_CH-1:0] pulso_largo
);

  localparam int TW = bits_for(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] div;
  logic          tick;

  assign tick = (div == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + TW'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    antirebote_multicanal_canal #(
      .COUNT_PRESS  (COUNT_PRESS),
      .COUNT_RELEASE(COUNT_RELEASE),
      .SYNC_STAGES  (SYNC_STAGES),
      .LONG_TICKS   (LONG_TICKS)
    ) u_canal (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .boton      (boton_in[i]),
      .nivel      (boton_out[i]),
      .pulso_sube (pulso_press[i]),
      .pulso_baja (pulso_release[i]),
      .pulso_largo(pulso_largo[i])
    );
  end

endmodule

// File: tb/tb_antirebote_multicanal.sv
// Directed bench for the multichannel debouncer with small thresholds so that
// press, bounce, release, long-press, reset and multi-channel cases run quickly.
module tb_antirebote_multicanal;

  logic       clk;
  logic       rst_n;
  logic [1:0] boton_in;
  logic [1:0] boton_out;
  logic [1:0] pulso_press;
  logic [1:0] pulso_release;
  logic [1:0] pulso_largo;

  int vectorCount = 0;
  int missCount   = 0;

  antirebote_multicanal #(
    .N_CH         (2),
    .COUNT_PRESS  (8),
    .COUNT_RELEASE(3),
    .SYNC_STAGES  (2),
    .TICK_DIV     (4),
    .LONG_TICKS   (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .boton_in     (boton_in),
    .boton_out    (boton_out),
    .pulso_press  (pulso_press),
    .pulso_release(pulso_release),
    .pulso_largo  (pulso_largo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] value);
    boton_in = value;
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic stepEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic sawHigh, sawLow, sawRelease;
    int   largoCount, firstLargo;

    rst_n = 1'b0;
    applyStimulus(2'b00);
    #2;
    checkOutput("reset_out", 32'(boton_out), 32'h0);
    checkOutput("reset_press", 32'(pulso_press), 32'h0);
    checkOutput("reset_release", 32'(pulso_release), 32'h0);
    checkOutput("reset_largo", 32'(pulso_largo), 32'h0);
    stepEdges(3);
    rst_n = 1'b1;
    stepEdges(3);

    // Clean press on ch0: level rises 10 edges after the input changes.
    applyStimulus(2'b01);
    stepEdges(9);
    checkOutput("press_early", 32'(boton_out), 32'h0);
    stepEdges(1);
    checkOutput("press_out", 32'(boton_out), 32'h1);
    checkOutput("press_pulse", 32'(pulso_press), 32'h1);
    stepEdges(1);
    checkOutput("press_pulse_width", 32'(pulso_press), 32'h0);
    checkOutput("press_ch1_idle", 32'(boton_out[1]), 32'h0);

    // Two-cycle low glitch must not release.
    applyStimulus(2'b00);
    stepEdges(2);
    applyStimulus(2'b01);
    sawLow = 1'b0;
    sawRelease = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepEdges(1);
      sawLow |= ~boton_out[0];
      sawRelease |= pulso_release[0];
    end
    checkOutput("glitch_no_drop", 32'(sawLow), 32'h0);
    checkOutput("glitch_no_release", 32'(sawRelease), 32'h0);

    // Real release: level falls 5 edges later.
    applyStimulus(2'b00);
    stepEdges(4);
    checkOutput("release_early", 32'(boton_out), 32'h1);
    stepEdges(1);
    checkOutput("release_out", 32'(boton_out), 32'h0);
    checkOutput("release_pulse", 32'(pulso_release), 32'h1);
    checkOutput("release_no_press", 32'(pulso_press), 32'h0);
    stepEdges(1);
    checkOutput("release_pulse_width", 32'(pulso_release), 32'h0);

    // Bounce every 5 clocks for 40 clocks never reaches the press threshold.
    sawHigh = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      applyStimulus((seg % 2 == 0) ? 2'b01 : 2'b00);
      for (int i = 0; i < 5; i++) begin
        stepEdges(1);
        sawHigh |= boton_out[0] | pulso_press[0];
      end
    end
    checkOutput("bounce_stays_low", 32'(sawHigh), 32'h0);
    applyStimulus(2'b01);
    stepEdges(9);
    checkOutput("bounce_hold_early", 32'(boton_out), 32'h0);
    stepEdges(1);
    checkOutput("bounce_hold_out", 32'(boton_out), 32'h1);
    checkOutput("bounce_hold_pulse", 32'(pulso_press), 32'h1);
    applyStimulus(2'b00);
    stepEdges(5);
    checkOutput("bounce_release", 32'(boton_out), 32'h0);

    // Long press: exactly one pulse 17..20 edges after the rise.
    applyStimulus(2'b01);
    stepEdges(10);
    checkOutput("long_rise", 32'(boton_out), 32'h1);
    largoCount = 0;
    firstLargo = 0;
    for (int j = 1; j <= 40; j++) begin
      stepEdges(1);
      if (pulso_largo != 2'b00) begin
        largoCount++;
        if (firstLargo == 0) firstLargo = j;
      end
    end
    checkOutput("long_count", 32'(largoCount), 32'h1);
    checkOutput("long_window", 32'(firstLargo >= 17 && firstLargo <= 20), 32'h1);
    applyStimulus(2'b00);
    stepEdges(5);
    checkOutput("long_release", 32'(boton_out), 32'h0);

    // Short hold of about 3 ticks gives no long pulse.
    applyStimulus(2'b01);
    stepEdges(10);
    checkOutput("short_rise", 32'(boton_out), 32'h1);
    largoCount = 0;
    for (int j = 0; j < 7; j++) begin
      stepEdges(1);
      if (pulso_largo != 2'b00) largoCount++;
    end
    applyStimulus(2'b00);
    for (int j = 0; j < 10; j++) begin
      stepEdges(1);
      if (pulso_largo != 2'b00) largoCount++;
    end
    checkOutput("short_no_largo", 32'(largoCount), 32'h0);
    checkOutput("short_released", 32'(boton_out), 32'h0);

    // Reset in the middle of a count on ch0 while ch1 is already high.
    applyStimulus(2'b10);
    stepEdges(10);
    checkOutput("pre_reset_ch1", 32'(boton_out), 32'h2);
    applyStimulus(2'b11);
    stepEdges(7);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out", 32'(boton_out), 32'h0);
    checkOutput("midreset_pulses", 32'({pulso_press, pulso_release, pulso_largo}), 32'h0);
    stepEdges(2);
    checkOutput("midreset_hold", 32'(boton_out), 32'h0);
    rst_n = 1'b1;
    stepEdges(9);
    checkOutput("postreset_early", 32'(boton_out), 32'h0);
    stepEdges(1);
    checkOutput("postreset_out", 32'(boton_out), 32'h3);
    checkOutput("postreset_press", 32'(pulso_press), 32'h3);

    // Simultaneous release on both channels.
    applyStimulus(2'b00);
    stepEdges(4);
    checkOutput("simul_rel_early", 32'(boton_out), 32'h3);
    stepEdges(1);
    checkOutput("simul_rel_out", 32'(boton_out), 32'h0);
    checkOutput("simul_rel_pulse", 32'(pulso_release), 32'h3);
    checkOutput("simul_rel_no_press", 32'(pulso_press), 32'h0);

    // Press ch0 while ch1 releases.
    applyStimulus(2'b10);
    stepEdges(10);
    checkOutput("cross_setup", 32'(boton_out), 32'h2);
    applyStimulus(2'b01);
    stepEdges(5);
    checkOutput("cross_rel_out", 32'(boton_out), 32'h0);
    checkOutput("cross_rel_pulse", 32'(pulso_release), 32'h2);
    checkOutput("cross_rel_no_press", 32'(pulso_press), 32'h0);
    stepEdges(5);
    checkOutput("cross_press_out", 32'(boton_out), 32'h1);
    checkOutput("cross_press_pulse", 32'(pulso_press), 32'h1);
    checkOutput("cross_press_no_rel", 32'(pulso_release), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
